word_queue: RTL

Parametrised word-delivery engine for the typing game. It keeps a lookahead queue of upcoming target words: slot 0 drives `current_word` and slot 1 drives `next_word`. Words are fetched from an external synchronous word ROM, selected either by an internal LFSR or sequentially. A handshake-free advance input, `word_complete`, is edge-detected inside the `clk` domain, so it is never used as a clock.

---
 rtl/word_queue_if.sv | 25 ++
 rtl/word_queue.sv | 85 ++++++++
 2 files changed

// File: rtl/word_queue_if.sv
// word_queue_if: game-side bus of the word queue (advance request, ROM port, queue outputs)
interface word_queue_if #(
  parameter int LETTER_W = 5,
  parameter int LETTERS = 4,
  parameter int DEPTH = 100
);
  localparam int WORD_W = LETTER_W * LETTERS;
  localparam int ADDR_W = $clog2(DEPTH);
  logic word_complete;
  logic mode_seq;
  logic [WORD_W-1:0] lib_data;
  logic [ADDR_W-1:0] lib_addr;
  logic [WORD_W-1:0] current_word;
  logic [WORD_W-1:0] next_word;
  logic ready;
  logic [15:0] words_delivered;
  modport master (
    output word_complete, mode_seq, lib_data,
    input  lib_addr, current_word, next_word, ready, words_delivered
  );
  modport slave (
    input  word_complete, mode_seq, lib_data,
    output lib_addr, current_word, next_word, ready, words_delivered
  );
endinterface

// File: rtl/word_queue.sv
// word_queue: lookahead queue of target words fetched from a synchronous word ROM
module word_queue #(
  parameter int LETTER_W = 5,
  parameter int LETTERS = 4,
  parameter int DEPTH = 100,
  parameter int LOOKAHEAD = 2,
  parameter logic [15:0] SEED = 16'hACE1,
  parameter bit NO_REPEAT = 1'b1
) (
  input logic clk,
  input logic reset,
  word_queue_if.slave bus
);
  localparam int WORD_W = LETTER_W * LETTERS;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int SLOTS = LOOKAHEAD + 1;
  localparam int IW = $clog2(SLOTS);
  typedef enum logic [1:0] {IDLE, SELECT, WAIT, CAPTURE} state_t;
  state_t state, state_n;
  logic [WORD_W-1:0] slot [SLOTS];
  logic [SLOTS-1:0] valid, valid_set;
  logic [IW-1:0] fill;
  logic [15:0] lfsr, cnt;
  logic [ADDR_W-1:0] last_idx, cand, addr;
  logic wc_q, pending, ready_q, adv, do_adv, accept;
  always_comb begin
    adv = bus.word_complete & ~wc_q;
    do_adv = (adv | pending) & ready_q & (state == IDLE);
    cand = bus.mode_seq ? ((last_idx == ADDR_W'(DEPTH - 1)) ? '0 : last_idx + ADDR_W'(1))
                        : lfsr[ADDR_W-1:0];
    accept = bus.mode_seq | ((32'(cand) < DEPTH) & ~(NO_REPEAT & (cand == last_idx)));
  end
  // Refill always targets the lowest empty slot so the initial fill runs head to tail.
  always_comb begin
    fill = '0;
    for (int i = SLOTS - 1; i >= 0; i--) if (!valid[i]) fill = IW'(i);
    valid_set = valid;
    valid_set[fill] = 1'b1;
  end
  always_comb begin
    state_n = state;
    if (state == SELECT && accept) state_n = WAIT;
    if (state == WAIT) state_n = CAPTURE;
    if (state == CAPTURE) state_n = (&valid_set) ? IDLE : SELECT;
    if (do_adv) state_n = SELECT;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= SELECT;
      lfsr <= SEED;
      last_idx <= ADDR_W'(DEPTH - 1);
      addr <= '0;
      wc_q <= 1'b0;
      pending <= 1'b0;
      ready_q <= 1'b0;
      valid <= '0;
      cnt <= '0;
      for (int i = 0; i < SLOTS; i++) slot[i] <= '0;
    end else begin
      state <= state_n;
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      wc_q <= bus.word_complete;
      if (state == SELECT && accept) begin
        addr <= cand;
        last_idx <= cand;
      end
      if (state == CAPTURE) begin
        slot[fill] <= bus.lib_data;
        valid[fill] <= 1'b1;
        ready_q <= &valid_set;
      end
      if (do_adv) begin
        for (int i = 0; i < LOOKAHEAD; i++) slot[i] <= slot[i+1];
        valid[LOOKAHEAD] <= 1'b0;
        ready_q <= 1'b0;
        cnt <= cnt + 16'd1;
        pending <= 1'b0;
      end else if (adv) pending <= 1'b1;
    end
  assign bus.lib_addr = addr;
  assign bus.current_word = slot[0];
  assign bus.next_word = slot[1];
  assign bus.ready = ready_q;
  assign bus.words_delivered = cnt;
endmodule
